// File: rtl/conv_gray_pkg.sv
// Shared types and helpers for the gray-to-binary receive path.
package conv_gray_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Zero-extension is harmless: leading zeros leave the XOR prefix unchanged.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic multi_bit(input logic [MAX_W-1:0] x);
    return (x & (x - 64'd1)) != 64'd0;
  endfunction

endpackage

// File: rtl/conv_gray_bin.sv
// Combinational gray-to-binary decoder.
module conv_gray_bin
  import conv_gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic [MAX_W-1:0] wide_bin;

  assign wide_bin = gray2bin(MAX_W'(gray_i));
  assign bin_o    = wide_bin[WIDTH-1:0];

endmodule

// File: rtl/conv_gray_bin_sync.sv
// Synchronizes an asynchronous gray value, decodes it, and reports changes,
// increments and multi-bit (illegal) transitions.
module conv_gray_bin_sync
  import conv_gray_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] gray_i,
  input  logic             err_clr_i,
  output logic [WIDTH-1:0] bin_o,
  output logic             bin_valid_o,
  output logic [WIDTH-1:0] delta_o,
  output logic             err_o
);

  localparam int CW = $clog2(SYNC_STAGES) + 1;

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] g_prev;
  logic [WIDTH-1:0] bin_d;
  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    fill_cnt;
  logic [CW-1:0]    fill_next;
  logic             changed;
  logic             multi;

  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    if (s == 0) begin : g_in
      assign d = gray_i;
    end else begin : g_chain
      assign d = g_sync[s-1].q;
    end
    // Plain synchronizer flop, nothing between stages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q <= '0;
      else         q <= d;
    end
  end

  assign g_s = g_sync[SYNC_STAGES-1].q;

  conv_gray_bin #(.WIDTH(WIDTH)) u_dec (
    .gray_i(g_s),
    .bin_o (bin_d)
  );

  // Next-state logic; change and error detection only qualify in RUN.
  always_comb begin
    state_next = state;
    fill_next  = fill_cnt;
    changed    = 1'b0;
    multi      = 1'b0;
    case (state)
      FILL: begin
        if (fill_cnt == CW'(SYNC_STAGES - 1)) begin
          state_next = PRIME;
          fill_next  = '0;
        end else begin
          fill_next = fill_cnt + CW'(1);
        end
      end
      PRIME: state_next = RUN;
      RUN: begin
        changed = (g_s != g_prev);
        multi   = changed && multi_bit(MAX_W'(g_s ^ g_prev));
      end
      default: begin
        state_next = FILL;
        fill_next  = '0;
      end
    endcase
  end

  // State and fill counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_next;
    end
  end

  // Output datapath: PRIME loads silently, RUN reports each accepted change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      g_prev      <= '0;
      bin_o       <= '0;
      delta_o     <= '0;
      bin_valid_o <= 1'b0;
    end else begin
      bin_valid_o <= changed;
      if (state == PRIME) begin
        g_prev  <= g_s;
        bin_o   <= bin_d;
        delta_o <= '0;
      end else if (changed) begin
        g_prev  <= g_s;
        bin_o   <= bin_d;
        delta_o <= bin_d - bin_o;
      end else begin
        g_prev  <= g_prev;
        bin_o   <= bin_o;
        delta_o <= delta_o;
      end
    end
  end

  // Sticky error; a new detection outranks a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        err_o <= 1'b0;
    else if (multi)     err_o <= 1'b1;
    else if (err_clr_i) err_o <= 1'b0;
    else                err_o <= err_o;
  end

endmodule

// File: tb/tb_conv_gray_bin_sync.sv
// Directed bench for conv_gray_bin_sync; runs every scenario on a 2-stage and a 3-stage instance.
module tb_conv_gray_bin_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] gray = 4'b0000;
  logic       err_clr = 1'b0;

  logic [3:0] bin2, delta2, bin3, delta3;
  logic       valid2, err2, valid3, err3;

  logic       sel = 1'b0;
  int         stages;
  logic [3:0] bin, delta;
  logic       valid, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_gray_bin_sync #(.WIDTH(4), .SYNC_STAGES(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .gray_i(gray), .err_clr_i(err_clr),
    .bin_o(bin2), .bin_valid_o(valid2), .delta_o(delta2), .err_o(err2)
  );

  conv_gray_bin_sync #(.WIDTH(4), .SYNC_STAGES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .gray_i(gray), .err_clr_i(err_clr),
    .bin_o(bin3), .bin_valid_o(valid3), .delta_o(delta3), .err_o(err3)
  );

  assign bin    = sel ? bin3 : bin2;
  assign delta  = sel ? delta3 : delta2;
  assign valid  = sel ? valid3 : valid2;
  assign err    = sel ? err3 : err2;
  assign stages = sel ? 3 : 2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] g);
    rst_n   = 1'b0;
    err_clr = 1'b0;
    gray    = g;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < stages + 2; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gray  = 4'b0110;
    tick();
    tick();
    tests++;
    if (bin !== 4'd0 || delta !== 4'd0 || valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state S=%0d: bin=%0d delta=%0d valid=%b err=%b, want 0 0 0 0",
               stages, bin, delta, valid, err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < stages; i++) begin
      tick();
      tests++;
      if (valid !== 1'b0 || bin !== 4'd0) begin
        fails++;
        $display("FAIL fill_quiet S=%0d cyc=%0d: valid=%b bin=%0d, want 0 0", stages, i, valid, bin);
      end
    end
    tick();
    tests++;
    if (bin !== 4'd4 || delta !== 4'd0 || valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL prime S=%0d: bin=%0d delta=%0d valid=%b err=%b, want 4 0 0 0",
               stages, bin, delta, valid, err);
    end
    tick();
    tests++;
    if (valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL post_prime S=%0d: valid=%b err=%b, want 0 0", stages, valid, err);
    end
  endtask

  task automatic test_step();
    logic [3:0] gseq [3];
    gseq[0] = 4'b0001;
    gseq[1] = 4'b0011;
    gseq[2] = 4'b0010;
    do_reset(4'b0000);
    for (int k = 0; k < 3; k++) begin
      gray = gseq[k];
      for (int i = 0; i < stages; i++) begin
        tick();
        tests++;
        if (valid !== 1'b0 || bin !== 4'(k)) begin
          fails++;
          $display("FAIL step_early S=%0d k=%0d: valid=%b bin=%0d, want 0 %0d", stages, k, valid, bin, k);
        end
      end
      tick();
      tests++;
      if (valid !== 1'b1 || bin !== 4'(k + 1) || delta !== 4'd1 || err !== 1'b0) begin
        fails++;
        $display("FAIL step S=%0d k=%0d: valid=%b bin=%0d delta=%0d err=%b, want 1 %0d 1 0",
                 stages, k, valid, bin, delta, err, k + 1);
      end
      tick();
      tests++;
      if (valid !== 1'b0) begin
        fails++;
        $display("FAIL step_pulse S=%0d k=%0d: valid=%b, want 0", stages, k, valid);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset(4'b1000);
    tests++;
    if (bin !== 4'd15 || valid !== 1'b0) begin
      fails++;
      $display("FAIL wrap_prime S=%0d: bin=%0d valid=%b, want 15 0", stages, bin, valid);
    end
    gray = 4'b0000;
    for (int i = 0; i <= stages; i++) tick();
    tests++;
    if (valid !== 1'b1 || bin !== 4'd0 || delta !== 4'd1 || err !== 1'b0) begin
      fails++;
      $display("FAIL wrap S=%0d: valid=%b bin=%0d delta=%0d err=%b, want 1 0 1 0",
               stages, valid, bin, delta, err);
    end
  endtask

  task automatic test_illegal();
    gray = 4'b0101;
    for (int i = 0; i <= stages; i++) tick();
    tests++;
    if (valid !== 1'b1 || bin !== 4'd6 || delta !== 4'd6 || err !== 1'b1) begin
      fails++;
      $display("FAIL illegal S=%0d: valid=%b bin=%0d delta=%0d err=%b, want 1 6 6 1",
               stages, valid, bin, delta, err);
    end
    tick();
    tick();
    tests++;
    if (err !== 1'b1 || valid !== 1'b0) begin
      fails++;
      $display("FAIL err_sticky S=%0d: err=%b valid=%b, want 1 0", stages, err, valid);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear S=%0d: err=%b, want 0", stages, err);
    end
  endtask

  task automatic test_clr_collide();
    gray = 4'b0000;
    for (int i = 0; i <= stages; i++) tick();
    tests++;
    if (err !== 1'b1 || bin !== 4'd0 || delta !== 4'd10) begin
      fails++;
      $display("FAIL collide_setup S=%0d: err=%b bin=%0d delta=%0d, want 1 0 10", stages, err, bin, delta);
    end
    gray = 4'b0110;
    for (int i = 0; i < stages; i++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++;
    if (err !== 1'b1 || valid !== 1'b1 || bin !== 4'd4 || delta !== 4'd4) begin
      fails++;
      $display("FAIL set_wins S=%0d: err=%b valid=%b bin=%0d delta=%0d, want 1 1 4 4",
               stages, err, valid, bin, delta);
    end
    tick();
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL set_wins_hold S=%0d: err=%b, want 1", stages, err);
    end
  endtask

  task automatic test_async_reset();
    do_reset(4'b0110);
    gray = 4'b1101;
    for (int i = 0; i <= stages; i++) tick();
    tests++;
    if (bin !== 4'd9 || delta !== 4'd5 || err !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset S=%0d: bin=%0d delta=%0d err=%b, want 9 5 1", stages, bin, delta, err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bin !== 4'd0 || delta !== 4'd0 || valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset S=%0d: bin=%0d delta=%0d valid=%b err=%b, want 0 0 0 0",
               stages, bin, delta, valid, err);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < stages + 3; i++) begin
      tick();
      tests++;
      if (valid !== 1'b0 || err !== 1'b0) begin
        fails++;
        $display("FAIL reprime_quiet S=%0d cyc=%0d: valid=%b err=%b, want 0 0", stages, i, valid, err);
      end
    end
    tests++;
    if (bin !== 4'd9 || delta !== 4'd0) begin
      fails++;
      $display("FAIL reprime S=%0d: bin=%0d delta=%0d, want 9 0", stages, bin, delta);
    end
  endtask

  initial begin
    for (int r = 0; r < 2; r++) begin
      sel = r[0];
      test_reset();
      test_step();
      test_wrap();
      test_illegal();
      test_clr_collide();
      test_async_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
